// File: rtl/inst_encoder.sv
// inst_encoder: two-stage RV32I instruction encoder feeding an IMEM write port.
// Ports: clk/rst, start/start_addr, request (in_valid/in_ready, op_class,
// funct3, alt, rd, rs1, rs2, imm), IMEM write (imem_we/imem_ready/imem_addr/
// imem_din), count of completed writes, sticky err.
module inst_encoder #(
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_class,
  input  logic [2:0]        funct3,
  input  logic              alt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic [15:0]       count,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_OP  = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  req_t        s1;
  logic        s1_valid;
  logic        s2_valid;
  logic [31:0] s2_word;
  logic        s1_adv;
  logic        s2_adv;
  logic        accept;
  logic        wr_done;
  logic [31:0] enc;
  logic        enc_err;

  // start_addr[1:0] are don't-care: writes are word aligned
  logic unused_lsb;
  assign unused_lsb = ^start_addr[1:0];

  assign s2_adv   = !s2_valid || imem_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;
  assign wr_done  = s2_valid && imem_ready;
  assign imem_we  = s2_valid;
  assign imem_din = s2_word;

  // one-hot op decode
  logic is_lui, is_aui, is_jal, is_jlr, is_br;
  logic is_ld, is_st, is_r, is_i;
  assign is_lui = s1.op == 4'd0;
  assign is_aui = s1.op == 4'd1;
  assign is_jal = s1.op == 4'd2;
  assign is_jlr = s1.op == 4'd3;
  assign is_br  = s1.op == 4'd4;
  assign is_ld  = s1.op == 4'd5;
  assign is_st  = s1.op == 4'd6;
  assign is_r   = s1.op == 4'd7;
  assign is_i   = s1.op == 4'd8;

  // immediate range checks: upper bits must be pure sign extension
  logic i_ok, b_ok, j_ok;
  assign i_ok = &s1.imm[31:11] || ~|s1.imm[31:11];
  assign b_ok = &s1.imm[31:12] || ~|s1.imm[31:12];
  assign j_ok = &s1.imm[31:20] || ~|s1.imm[31:20];

  logic [6:0] f7;
  assign f7 = s1.alt ? 7'b0100000 : 7'b0000000;

  always_comb begin
    enc     = NOP;
    enc_err = 1'b0;
    unique case (1'b1)
      is_lui: begin
        enc     = {s1.imm[31:12], s1.rd, OP_LUI};
        enc_err = |s1.imm[11:0];
      end
      is_aui: begin
        enc     = {s1.imm[31:12], s1.rd, OP_AUI};
        enc_err = |s1.imm[11:0];
      end
      is_jal: begin
        enc     = {s1.imm[20], s1.imm[10:1],
                   s1.imm[11], s1.imm[19:12],
                   s1.rd, OP_JAL};
        enc_err = s1.imm[0] || !j_ok;
      end
      is_jlr: begin
        enc     = {s1.imm[11:0], s1.rs1, 3'b000,
                   s1.rd, OP_JLR};
        enc_err = !i_ok;
      end
      is_br: begin
        enc     = {s1.imm[12], s1.imm[10:5],
                   s1.rs2, s1.rs1, s1.f3,
                   s1.imm[4:1], s1.imm[11], OP_BR};
        enc_err = s1.imm[0] || !b_ok ||
                  s1.f3 == 3'b010 || s1.f3 == 3'b011;
      end
      is_ld: begin
        enc     = {s1.imm[11:0], s1.rs1, s1.f3,
                   s1.rd, OP_LD};
        enc_err = !i_ok || s1.f3 == 3'b011 ||
                  s1.f3 == 3'b110 || s1.f3 == 3'b111;
      end
      is_st: begin
        enc     = {s1.imm[11:5], s1.rs2, s1.rs1,
                   s1.f3, s1.imm[4:0], OP_ST};
        enc_err = !i_ok || s1.f3 >= 3'b011;
      end
      is_r: begin
        enc = {f7, s1.rs2, s1.rs1, s1.f3,
               s1.rd, OP_OP};
      end
      is_i: begin
        if (s1.f3 == 3'b001)
          enc = {7'b0000000, s1.imm[4:0], s1.rs1,
                 s1.f3, s1.rd, OP_IMM};
        else if (s1.f3 == 3'b101)
          enc = {f7, s1.imm[4:0], s1.rs1,
                 s1.f3, s1.rd, OP_IMM};
        else
          enc = {s1.imm[11:0], s1.rs1, s1.f3,
                 s1.rd, OP_IMM};
        enc_err = !i_ok;
      end
      default: begin
        enc     = NOP;
        enc_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      if (accept)
        s1_valid <= 1'b1;
      else if (s1_adv)
        s1_valid <= 1'b0;
      if (accept) begin
        s1.op  <= op_class;
        s1.f3  <= funct3;
        s1.alt <= alt;
        s1.rd  <= rd;
        s1.rs1 <= rs1;
        s1.rs2 <= rs2;
        s1.imm <= imm;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_word  <= '0;
      err      <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_word  <= enc;
      err      <= err || enc_err;
    end else if (imem_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // start beats a same-cycle completion; the completed
  // word was already presented at the old address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr <= BASE;
      count     <= '0;
    end else if (start) begin
      imem_addr <= {start_addr[ADDR_W-1:2], 2'b00};
      count     <= '0;
    end else if (wr_done) begin
      imem_addr <= imem_addr + ADDR_W'(4);
      if (count != 16'hFFFF)
        count <= count + 16'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed vectors for inst_encoder.
// Captures IMEM writes at the clock edge and checks them in order.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] start_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_class;
  logic [2:0]  funct3;
  logic        alt;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        imem_we;
  logic        imem_ready;
  logic [13:0] imem_addr;
  logic [31:0] imem_din;
  logic [15:0] count;
  logic        err;

  inst_encoder #(.ADDR_W(14), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_class   (op_class),
    .funct3     (funct3),
    .alt        (alt),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_din   (imem_din),
    .count      (count),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_wc = 0;
  logic [13:0] wa_q[$];
  logic [31:0] wd_q[$];
  int wc_q[$];
  int acc_q[$];

  always @(posedge clk) begin
    if (imem_we && imem_ready) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_din);
      wc_q.push_back(cyc);
    end
    cyc++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] o,
                         input logic [2:0] f,
                         input logic a,
                         input logic [4:0] d,
                         input logic [4:0] s1,
                         input logic [4:0] s2,
                         input logic [31:0] i);
    op_class = o;
    funct3   = f;
    alt      = a;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    imm      = i;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [3:0] o,
                      input logic [2:0] f,
                      input logic a,
                      input logic [4:0] d,
                      input logic [4:0] s1,
                      input logic [4:0] s2,
                      input logic [31:0] i);
    int t = 0;
    set_req(o, f, a, d, s1, s2, i);
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready)
      chk("send_timeout", 32'(in_ready), 32'd1);
    acc_q.push_back(cyc);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_wr(input string tag,
                           input logic [13:0] a,
                           input logic [31:0] d);
    int t = 0;
    while (wa_q.size() == 0 && t < 50) begin
      tick();
      t++;
    end
    if (wa_q.size() == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_addr"}, 32'(wa_q.pop_front()), 32'(a));
      chk({tag, "_data"}, wd_q.pop_front(), d);
      last_wc = wc_q.pop_front();
    end
  endtask

  task automatic wait_we();
    int t = 0;
    while (!imem_we && t < 20) begin
      tick();
      t++;
    end
    chk("wait_we", 32'(imem_we), 32'd1);
  endtask

  int w0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start_addr = '0;
    in_valid = 1'b0;
    imem_ready = 1'b1;
    set_req(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst_we",    32'(imem_we),   32'd0);
    chk("rst_din",   imem_din,       32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_err",   32'(err),       32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rdy",   32'(in_ready),  32'd1);

    // 1: back-to-back stream
    acc_q.delete();
    send(4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    send(4'd7, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    send(4'd7, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    send(4'd8, 3'd5, 1'b1, 5'd4, 5'd1, 5'd0, 32'd3);
    expect_wr("t1_addi", 14'h0, 32'h0050_0093);
    chk("t1_lat0", 32'(last_wc - acc_q.pop_front()), 32'd2);
    expect_wr("t1_add", 14'h4, 32'h0020_81B3);
    chk("t1_lat1", 32'(last_wc - acc_q.pop_front()), 32'd2);
    expect_wr("t1_sub", 14'h8, 32'h4020_81B3);
    chk("t1_lat2", 32'(last_wc - acc_q.pop_front()), 32'd2);
    expect_wr("t1_srai", 14'hC, 32'h4030_D213);
    chk("t1_lat3", 32'(last_wc - acc_q.pop_front()), 32'd2);
    chk("t1_count", 32'(count), 32'd4);
    chk("t1_err",   32'(err),   32'd0);

    // 2: format coverage
    send(4'd0, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    send(4'd2, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    send(4'd6, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    expect_wr("t2_lui", 14'h10, 32'h1234_52B7);
    expect_wr("t2_jal", 14'h14, 32'h0080_00EF);
    expect_wr("t2_beq", 14'h18, 32'hFE20_8EE3);
    expect_wr("t2_sw",  14'h1C, 32'h0020_A423);
    chk("t2_count", 32'(count), 32'd8);
    chk("t2_err",   32'(err),   32'd0);

    // 3: backpressure
    imem_ready = 1'b0;
    set_req(4'd8, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd1);
    chk("t3_rdy_a", 32'(in_ready), 32'd1);
    tick();
    set_req(4'd8, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'd2);
    chk("t3_rdy_b", 32'(in_ready), 32'd1);
    tick();
    set_req(4'd8, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd3);
    chk("t3_rdy_c", 32'(in_ready), 32'd0);
    chk("t3_we",    32'(imem_we),  32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_hold_rdy", 32'(in_ready), 32'd0);
      chk("t3_hold_din", imem_din, 32'h0010_0293);
      chk("t3_hold_adr", 32'(imem_addr), 32'h20);
    end
    imem_ready = 1'b1;
    #1;
    chk("t3_rdy_rel", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    expect_wr("t3_a", 14'h20, 32'h0010_0293);
    w0 = last_wc;
    expect_wr("t3_b", 14'h24, 32'h0020_0313);
    chk("t3_gap_b", 32'(last_wc - w0), 32'd1);
    expect_wr("t3_c", 14'h28, 32'h0030_0393);
    chk("t3_gap_c", 32'(last_wc - w0), 32'd2);
    chk("t3_count", 32'(count), 32'd11);

    // 4: errors
    send(4'd12, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd7);
    expect_wr("t4_nop", 14'h2C, 32'h0000_0013);
    chk("t4_err_set", 32'(err), 32'd1);
    send(4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    expect_wr("t4_addi", 14'h30, 32'h0050_0093);
    chk("t4_err_stk", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_err_rst", 32'(err), 32'd0);
    chk("t4_adr_rst", 32'(imem_addr), 32'd0);
    send(4'd0, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5001);
    expect_wr("t4_lui", 14'h0, 32'h1234_52B7);
    chk("t4_err_lui", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // 5: address control
    start_addr = 14'h3FFD;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_st_adr", 32'(imem_addr), 32'h3FFC);
    chk("t5_st_cnt", 32'(count), 32'd0);
    send(4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    send(4'd7, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_wr("t5_top", 14'h3FFC, 32'h0050_0093);
    expect_wr("t5_wrap", 14'h0, 32'h0020_81B3);
    chk("t5_cnt2", 32'(count), 32'd2);
    imem_ready = 1'b0;
    send(4'd6, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    wait_we();
    start_addr = 14'h0100;
    start = 1'b1;
    imem_ready = 1'b1;
    tick();
    start = 1'b0;
    expect_wr("t5_sc", 14'h4, 32'h0020_A423);
    chk("t5_sc_adr", 32'(imem_addr), 32'h100);
    chk("t5_sc_cnt", 32'(count), 32'd0);

    // 6: async reset mid-transfer
    imem_ready = 1'b0;
    send(4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    send(4'd8, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd6);
    wait_we();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_we",  32'(imem_we),   32'd0);
    chk("t6_adr", 32'(imem_addr), 32'd0);
    chk("t6_cnt", 32'(count),     32'd0);
    chk("t6_din", imem_din,       32'd0);
    tick();
    rst = 1'b0;
    imem_ready = 1'b1;
    repeat (6) tick();
    chk("t6_nowr",  32'(wa_q.size()), 32'd0);
    chk("t6_we_q",  32'(imem_we),     32'd0);
    chk("t6_cnt_q", 32'(count),       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streams decoded instruction requests in and emits legal RV32I instruction words out. It is the encoder counterpart to the core's opcode/funct control decode.
- Each request carries an op class plus register and immediate fields.
- Each encoded word is written to instruction memory at an auto-incrementing address.
- Used by the BIOS program loader and by self-checking benches to build test programs in IMEM.
- Two-stage pipeline with valid/ready input and a backpressured IMEM write port.

Parameters:
ADDR_W, 14, width of the IMEM byte address
BASE_ADDR, 0, address loaded at reset

Ports:
clk input 1 clock; all state changes on rising edge
rst input 1 asynchronous active-high reset
start input 1 sync pulse; reloads the write address from start_addr
start_addr input ADDR_W byte address to load on start; bits [1:0] ignored
in_valid input 1 request valid
in_ready output 1 encoder can accept a request
op_class input 4 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 ARI_R, 8 ARI_I, 9-15 illegal
funct3 input 3 funct3 field
alt input 1 instruction bit 30 (SUB/SRA select)
rd input 5 destination register
rs1 input 5 source register 1
rs2 input 5 source register 2
imm input 32 byte-granular immediate, sign-extended value
imem_we output 1 write valid
imem_ready input 1 IMEM accepts the write this cycle
imem_addr output ADDR_W byte address of the write
imem_din output 32 encoded instruction word
count output 16 completed writes since reset or start; saturates at 0xFFFF
err output 1 sticky error flag

Behaviour:
- Reset (async, rst=1): all valid flags 0, imem_we=0, imem_din=0, imem_addr=BASE_ADDR, count=0, err=0. in_ready=1 once rst deasserts. Reset mid-transfer discards both stages and writes nothing further.
- Pipeline:
  - S1 registers request fields on accept (in_valid&&in_ready).
  - S2 holds the encoded word and drives imem_we.
  - Latency: accept at edge N -> imem_we=1 from cycle N+2.
- Handshake:
  - s2_adv = !s2_valid || imem_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv (combinational).
  - imem_addr and imem_din stay stable while imem_we=1 && !imem_ready.
  - Full throughput: one word per cycle when imem_ready=1.
- Write completion (imem_we && imem_ready):
  - imem_addr += 4, wrapping modulo 2^ADDR_W.
  - count += 1, saturating at 0xFFFF.
- start:
  - imem_addr <= {start_addr[ADDR_W-1:2],2'b00}; count <= 0.
  - If start coincides with a completion, start wins; the completed word still belongs to the old address.
  - Pipeline contents are not flushed.
- Encoding (opcodes per RV32I):
  - LUI/AUIPC: imm[31:12].
  - JAL: J-format from imm[20:1].
  - JALR: I-format, funct3=000.
  - BRANCH: B-format from imm[12:1] with funct3.
  - LOAD: I-format with funct3.
  - STORE: S-format with funct3.
  - ARI_R: funct7 = alt ? 0100000 : 0000000.
  - ARI_I:
    - funct3 001: imm[4:0] as shamt, funct7=0000000.
    - funct3 101: imm[4:0] as shamt, funct7 = alt ? 0100000 : 0000000.
    - Other funct3: imm[11:0].
- Errors: err sets at S1->S2 transfer and stays set until rst. Error cases:
  - Illegal op_class: the word is replaced with NOP 0x00000013.
  - JAL/BRANCH with imm[0]=1: imm[0] is dropped and encoding proceeds.
  - JAL imm outside ±1 MiB or BRANCH imm outside ±4 KiB: encoded with truncated bits.
  - I-, S- or JALR-type imm outside [-2048,2047].
  - LUI/AUIPC with imm[11:0]≠0.
  - BRANCH funct3 010 or 011, LOAD funct3 011, 110 or 111, STORE funct3 ≥ 011.
- No write occurs for a request dropped by reset. An errored request is still written (NOP or truncated form).

Test Plan:
1. Reset, imem_ready=1, back-to-back stream:
   - addi x1,x0,5 -> 0x00500093 @0x0
   - add x3,x1,x2 -> 0x002081B3 @0x4
   - sub x3,x1,x2 (alt=1) -> 0x402081B3 @0x8
   - srai x4,x1,3 -> 0x4030D213 @0xC
   - Required: each word 2 cycles after its accept, count=4, err=0.
2. Format coverage:
   - lui x5 imm=0x12345000 -> 0x123452B7
   - jal x1 imm=8 -> 0x008000EF
   - beq x1,x2 imm=-4 -> 0xFE208EE3
   - sw x2,8(x1) -> 0x0020A423
3. Backpressure: hold imem_ready=0 and offer 3 requests.
   - Required: 2 accepted, then in_ready=0.
   - Required: imem_din/imem_addr stable throughout.
   - Release: 3 writes on consecutive cycles, addresses +4 each.
4. Errors:
   - op_class=12 -> 0x00000013 written, err=1.
   - Then a valid addi -> err stays 1.
   - rst -> err=0.
5. Address control:
   - start with start_addr=0x3FFD -> first write @0x3FFC, next @0x0000 (wrap).
   - start asserted on a completion cycle -> next address = start_addr, count=0.
6. Reset mid-operation: assert rst asynchronously while imem_we=1 && imem_ready=0.
   - Required immediately: imem_we=0, imem_addr=BASE_ADDR, count=0.
   - Required: no stale write after rst deasserts.
